// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: control FSM that steps an external 16-bit PC register
// through fetch, decode hand-off and execute, selecting PC+1 or a branch
// target after each instruction and stopping on halt.
//
// Handshakes (all qualified on the rising clock edge):
//   fetch   : mem_req is held high in FETCH; a cycle with mem_req=1 and
//             mem_ready=1 transfers mem_rdata into ir.
//   decode  : ir_valid=1 offers ir; a cycle with ir_valid=1 and ir_accept=1
//             hands it over, and ir_valid drops on that edge.
//   execute : in EXEC, a cycle with exec_done=1 retires the instruction;
//             branch_taken, branch_target and halt_req are sampled only then.
// mem_ready, ir_accept and exec_done are ignored in every other state.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_data,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_accept,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
    output logic               busy,
    output logic               halted,
    output logic [2:0]         state
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       fetch_fire;
    logic       accept_fire;
    logic       exec_fire;

    assign fetch_fire  = (state_q == S_FETCH) && mem_ready;
    assign accept_fire = (state_q == S_HOLD) && ir_accept;
    assign exec_fire   = (state_q == S_EXEC) && exec_done;

    // Next-state selection; the EXEC exit picks HALT, FETCH or IDLE in one step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_IDLE;
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_HOLD;
            S_HOLD:  if (ir_accept) state_d = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (halt_req)  state_d = S_HALT;
                    else if (run)  state_d = S_FETCH;
                    else           state_d = S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // State register; reset forces BOOT so the PC gets reloaded on release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_BOOT;
        else         state_q <= state_d;
    end

    // Instruction register and its valid flag; loaded on fetch, freed on accept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (fetch_fire) begin
                ir       <= mem_rdata;
                ir_valid <= 1'b1;
            end else if (accept_fire) begin
                ir_valid <= 1'b0;
            end
        end
    end

    // PC controls and status decode straight from state so reset takes effect
    // immediately; halt outranks branch, which outranks the increment.
    always_comb begin
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        pc_data = RESET_VECTOR;
        if (state_q == S_BOOT) begin
            pc_load = 1'b1;
        end else if (exec_fire && !halt_req) begin
            if (branch_taken) begin
                pc_load = 1'b1;
                pc_data = branch_target;
            end else begin
                pc_inc = 1'b1;
            end
        end
    end

    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_HOLD) || (state_q == S_EXEC);
    assign halted   = (state_q == S_HALT);
    assign state    = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: drives pc_fetch_sequencer against a PC register
// model and a reference of the instruction stream (address sequence, fetched
// words and expected PC update per instruction). A negedge monitor pops the
// expected queues whenever the DUT presents a fetch, a decode hand-off or a
// PC update pulse.
module tb_pc_fetch_sequencer;

    localparam logic [15:0] RV = 16'h0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] pc_q = 16'h1234;
    logic        pc_inc, pc_load;
    logic [15:0] pc_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_accept = 1'b0;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic        busy, halted;
    logic [2:0]  fsm_state;

    pc_fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .RESET_VECTOR(RV)) dut (
        .clock(clock), .resetn(resetn), .run(run), .pc_q(pc_q),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_data(pc_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
        .ir_accept(ir_accept), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .busy(busy), .halted(halted), .state(fsm_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // External PC register the sequencer controls.
    always @(posedge clock) begin
        if (pc_load)     pc_q <= pc_data;
        else if (pc_inc) pc_q <= pc_q + 16'd1;
    end

    // scoreboard state
    logic [15:0] addr_q[$];
    logic [15:0] ir_q[$];
    logic [17:0] act_q[$];   // {pc_inc, pc_load, pc_data}
    logic [15:0] exp_pc;
    logic        mon_en = 1'b0;
    logic [2:0]  boot_code;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares whenever the DUT presents an output event
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_req && mem_ready) begin
                if (addr_q.size() == 0) chk("fetch_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                else                    chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (ir_valid && ir_accept) begin
                if (ir_q.size() == 0) chk("accept_unexpected", 32'(ir), 32'hFFFF_FFFF);
                else                  chk("ir_handoff", 32'(ir), 32'(ir_q.pop_front()));
            end
            if (pc_inc || pc_load) begin
                if (act_q.size() == 0) chk("pc_pulse_unexpected", {14'd0, pc_inc, pc_load, pc_data}, 32'd0);
                else                   chk("pc_update", {14'd0, pc_inc, pc_load, pc_data}, {14'd0, act_q.pop_front()});
            end else begin
                chk("pc_data_idle", 32'(pc_data), 32'(RV));
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_spurious;
        mem_ready = 1'b0; exec_done = 1'b0; ir_accept = 1'b0;
        branch_taken = 1'b0; halt_req = 1'b0;
    endtask

    // Reset held, then released: one BOOT cycle loading RV, then quiet IDLE.
    task automatic do_boot;
        run = 1'b0;
        resetn = 1'b0;
        tick; tick;
        chk("rst_pc_load", 32'(pc_load), 32'd1);
        chk("rst_pc_data", 32'(pc_data), 32'(RV));
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir", {15'd0, ir_valid, ir}, 32'd0);
        chk("rst_status", {busy, halted, pc_inc}, 32'd0);
        resetn = 1'b1;
        #1;
        chk("boot_pc_load", 32'(pc_load), 32'd1);
        boot_code = fsm_state;
        tick;
        chk("idle_outputs", {pc_inc, pc_load, mem_req, ir_valid, busy, halted}, 32'd0);
        chk("boot_pc_loaded", 32'(pc_q), 32'(RV));
        exp_pc = RV;
        addr_q.delete(); ir_q.delete(); act_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            tick;
        end
        if (!ok) chk("fetch_timeout", 32'(mem_req), 32'd1);
    endtask

    // One instruction through fetch, decode hand-off and execute.
    task automatic do_instr(input bit br, input logic [15:0] tgt, input bit hlt,
                            input bit run_after, input int lat, input int stall);
        bit          ok;
        logic [15:0] d;
        int          l, s, e;
        l = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
        s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        e = int'($urandom_range(0, 3));
        addr_q.push_back(exp_pc);
        wait_fetch(ok);
        if (!ok) return;
        repeat (l) begin
            if (!mem_req) chk("mem_req_held", 32'(mem_req), 32'd1);
            tick;
        end
        d = 16'($urandom);
        mem_ready = 1'b1;
        mem_rdata = d;
        ir_q.push_back(d);
        tick;
        mem_ready = 1'b0;
        // decode stall: ir must stay put while stray strobes are ignored
        for (int i = 0; i < s; i++) begin
            chk("hold_valid", 32'(ir_valid), 32'd1);
            chk("hold_ir", 32'(ir), 32'(d));
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            exec_done = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            run = 1'($urandom_range(0, 1));
            tick;
            clear_spurious;
        end
        ir_accept = 1'b1;
        tick;
        ir_accept = 1'b0;
        chk("exec_ir_valid", 32'(ir_valid), 32'd0);
        repeat (e) begin
            ir_accept = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            tick;
            clear_spurious;
        end
        exec_done = 1'b1;
        branch_taken = br;
        branch_target = tgt;
        halt_req = hlt;
        run = run_after;
        if (!hlt) begin
            if (br) act_q.push_back({2'b01, tgt});
            else    act_q.push_back({2'b10, RV});
            exp_pc = br ? tgt : exp_pc + 16'd1;
        end
        tick;
        clear_spurious;
        branch_target = 16'($urandom);
        if (hlt) begin
            repeat (5) begin
                chk("halt_status", {halted, busy, mem_req}, 32'b100);
                run = 1'b1;
                exec_done = 1'b1;
                ir_accept = 1'b1;
                tick;
                clear_spurious;
            end
        end else if (!run_after) begin
            repeat (3) begin
                chk("stopped_idle", {busy, mem_req, halted}, 32'd0);
                tick;
            end
            run = 1'b1;
            tick;
        end
    endtask

    // Reset asserted in the middle of a fetch: request must drop at once.
    task automatic reset_in_fetch;
        bit ok;
        wait_fetch(ok);
        if (!ok) return;
        chk("wrap_fetch_addr", 32'(mem_addr), 32'(exp_pc));
        mon_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_boot_state", 32'(fsm_state), 32'(boot_code));
        chk("abort_pc_load", {pc_load, busy, ir_valid}, 32'b100);
        do_boot;
    endtask

    initial begin
        do_boot;
        run = 1'b1;
        do_instr(1'b1, 16'h0005, 1'b0, 1'b1, 0, 0);   // 0000: jump to 0005
        do_instr(1'b0, 16'h0000, 1'b0, 1'b1, 2, 1);   // 0005: straight line
        do_instr(1'b1, 16'h00A0, 1'b0, 1'b1, 1, 0);   // 0006: branch to 00A0
        do_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 5);   // 00A0: stall, then stop
        do_instr(1'b1, 16'hFFFF, 1'b0, 1'b1, -1, -1); // 00A1: jump to FFFF
        do_instr(1'b0, 16'h0000, 1'b0, 1'b1, -1, -1); // FFFF: wrap to 0000
        reset_in_fetch;
        run = 1'b1;
        for (int k = 0; k < 30; k++) begin
            do_instr(($urandom_range(0, 3) == 0), 16'($urandom), 1'b0,
                     ($urandom_range(0, 4) != 0), -1, -1);
        end
        do_instr(1'b1, 16'h1234, 1'b1, 1'b1, -1, -1);  // halt beats branch
        chk("queues_drained", addr_q.size() + ir_q.size() + act_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
